// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler
//   Round-robin arbiter + frame serialiser for a byte-wide UDP TX path.
//   For each frame: grant one requester, present its payload length to the
//   external header generator, wait for the header to settle, then emit
//   header bytes, the granted source's payload, zero padding up to the
//   minimum frame size, and finally hold off for the inter-frame gap.
//
// Ports
//   clk_i, arstn_i            clock, async active-low reset
//   req_valid_i/req_len_i     per-source frame request and payload length
//   req_ack_o                 one-cycle grant pulse per source
//   s_data_i/s_valid_i/s_ready_o  per-source payload byte streams
//   payload_bytes_o           length of the granted payload (to header gen)
//   header_i                  header bytes, byte n at [8n+7:8n]
//   m_data_o/m_valid_o/m_last_o/m_ready_i  TX byte stream to the MAC
//   busy_o                    frame in progress
//   grant_o                   index of current/last granted source
module udp_tx_scheduler #(
    parameter int NUM_SRC         = 4,
    parameter int PAYLOAD_WIDTH   = 11,
    parameter int HDR_BYTES       = 42,
    parameter int HDR_LATENCY     = 2,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_CYCLES      = 12
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic [NUM_SRC-1:0]               req_valid_i,
    input  logic [NUM_SRC*PAYLOAD_WIDTH-1:0] req_len_i,
    output logic [NUM_SRC-1:0]               req_ack_o,
    input  logic [NUM_SRC*8-1:0]             s_data_i,
    input  logic [NUM_SRC-1:0]               s_valid_i,
    output logic [NUM_SRC-1:0]               s_ready_o,
    output logic [PAYLOAD_WIDTH-1:0]         payload_bytes_o,
    input  logic [HDR_BYTES*8-1:0]           header_i,
    output logic [7:0]                       m_data_o,
    output logic                             m_valid_o,
    output logic                             m_last_o,
    input  logic                             m_ready_i,
    output logic                             busy_o,
    output logic [$clog2(NUM_SRC)-1:0]       grant_o
);

    localparam int GW  = $clog2(NUM_SRC);
    localparam int CW  = PAYLOAD_WIDTH + 1;          // byte counter, never wraps at max len
    localparam int HIW = $clog2(HDR_BYTES);
    localparam int WW  = $clog2(HDR_LATENCY + 1);
    localparam int FW  = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HDR_WAIT, HDR, PAYLOAD, PAD, GAP} state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            ptr_q, grant_q;
    logic [PAYLOAD_WIDTH-1:0] len_q;
    logic [CW-1:0]            bcnt_q;   // header index / payload count / frame byte count in PAD
    logic [WW-1:0]            wait_q;
    logic [FW-1:0]            gap_q;

    // Unpacked views of the flat buses
    logic [PAYLOAD_WIDTH-1:0] len_arr   [NUM_SRC];
    logic [7:0]               src_bytes [NUM_SRC];
    logic [7:0]               hdr_bytes [HDR_BYTES];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign len_arr[k]   = req_len_i[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        assign src_bytes[k] = s_data_i[k*8 +: 8];
    end
    for (genvar n = 0; n < HDR_BYTES; n++) begin : g_hdr
        assign hdr_bytes[n] = header_i[n*8 +: 8];
    end

    // Round-robin pick: first requester at or after the pointer, cyclic
    logic          arb_hit;
    logic [GW-1:0] arb_idx, arb_nxt;
    int            c;

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        arb_nxt = '0;
        c       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            c = (int'(ptr_q) + i) % NUM_SRC;
            if (!arb_hit && req_valid_i[c]) begin
                arb_hit = 1'b1;
                arb_idx = GW'(c);
                arb_nxt = GW'((c + 1) % NUM_SRC);
            end
        end
    end

    // Frames shorter than the minimum get zero padding after the payload
    logic short_frame;
    assign short_frame = (HDR_BYTES + int'({1'b0, len_q})) < MIN_FRAME_BYTES;

    logic hdr_end, pay_end, pad_end, len_zero;
    assign len_zero = (len_q == '0);
    assign hdr_end  = (bcnt_q == CW'(HDR_BYTES - 1));
    assign pay_end  = ((bcnt_q + 1'b1) == {1'b0, len_q});
    assign pad_end  = (bcnt_q == CW'(MIN_FRAME_BYTES - 1));

    always_comb begin
        state_d   = state_q;
        m_valid_o = 1'b0;
        m_data_o  = 8'h00;
        m_last_o  = 1'b0;
        s_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (arb_hit) state_d = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (wait_q == WW'(HDR_LATENCY - 1)) state_d = HDR;
            end
            HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = hdr_bytes[bcnt_q[HIW-1:0]];
                // Empty payload with a header already at minimum size ends here
                m_last_o  = hdr_end && len_zero && !short_frame;
                if (m_ready_i && hdr_end) begin
                    if (!len_zero)        state_d = PAYLOAD;
                    else if (short_frame) state_d = PAD;
                    else                  state_d = GAP;
                end
            end
            PAYLOAD: begin
                m_valid_o          = s_valid_i[grant_q];
                m_data_o           = src_bytes[grant_q];
                m_last_o           = pay_end && !short_frame;
                s_ready_o[grant_q] = m_ready_i;
                if (s_valid_i[grant_q] && m_ready_i && pay_end)
                    state_d = short_frame ? PAD : GAP;
            end
            PAD: begin
                m_valid_o = 1'b1;
                m_last_o  = pad_end;
                if (m_ready_i && pad_end) state_d = GAP;
            end
            GAP: begin
                if (gap_q == FW'(IFG_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic acc;
    assign acc = m_valid_o & m_ready_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            grant_q         <= '0;
            len_q           <= '0;
            bcnt_q          <= '0;
            wait_q          <= '0;
            gap_q           <= '0;
            req_ack_o       <= '0;
            payload_bytes_o <= '0;
        end else begin
            state_q   <= state_d;
            req_ack_o <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        req_ack_o[arb_idx] <= 1'b1;
                        len_q              <= len_arr[arb_idx];
                        payload_bytes_o    <= len_arr[arb_idx];
                        grant_q            <= arb_idx;
                        ptr_q              <= arb_nxt;
                        wait_q             <= '0;
                        bcnt_q             <= '0;
                    end
                end
                HDR_WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    gap_q  <= '0;
                end
                HDR: begin
                    if (acc) begin
                        if (!hdr_end)      bcnt_q <= bcnt_q + 1'b1;
                        else if (len_zero) bcnt_q <= CW'(HDR_BYTES);
                        else               bcnt_q <= '0;
                    end
                end
                PAYLOAD: begin
                    // On the last payload byte switch to counting whole-frame bytes for PAD
                    if (acc) bcnt_q <= pay_end ? (CW'(HDR_BYTES) + {1'b0, len_q}) : (bcnt_q + 1'b1);
                end
                PAD: begin
                    if (acc) bcnt_q <= bcnt_q + 1'b1;
                end
                GAP: begin
                    gap_q <= gap_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
module tb_udp_tx_scheduler;

    localparam int NS  = 4;
    localparam int PW  = 11;
    localparam int HB  = 42;
    localparam int MIN = 60;
    localparam int IFG = 12;

    logic                 clk_i = 1'b0;
    logic                 arstn_i = 1'b0;
    logic [NS-1:0]        req_valid_i = '0;
    logic [NS*PW-1:0]     req_len_i = '0;
    logic [NS-1:0]        req_ack_o;
    logic [NS*8-1:0]      s_data_i;
    logic [NS-1:0]        s_valid_i = '1;
    logic [NS-1:0]        s_ready_o;
    logic [PW-1:0]        payload_bytes_o;
    logic [HB*8-1:0]      header_i;
    logic [7:0]           m_data_o;
    logic                 m_valid_o, m_last_o;
    logic                 m_ready_i = 1'b1;
    logic                 busy_o;
    logic [1:0]           grant_o;

    udp_tx_scheduler #(.NUM_SRC(NS), .PAYLOAD_WIDTH(PW), .HDR_BYTES(HB), .HDR_LATENCY(2),
                       .MIN_FRAME_BYTES(MIN), .IFG_CYCLES(IFG)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .req_valid_i(req_valid_i), .req_len_i(req_len_i),
        .req_ack_o(req_ack_o), .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .payload_bytes_o(payload_bytes_o), .header_i(header_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
        .grant_o(grant_o));

    always #5 clk_i = ~clk_i;

    int n_test = 0;
    int n_fail = 0;

    function automatic logic [7:0] hbyte(input logic [PW-1:0] l, input int n);
        return 8'((n * 13 + int'(l) * 5 + 33) & 255);
    endfunction

    function automatic logic [7:0] pbyte(input int k, input int i);
        return 8'((k * 61 + i * 3 + 1) & 255);
    endfunction

    // Header generator model: two-cycle latency from payload_bytes_o
    logic [PW-1:0] hd1, hd2;
    always @(posedge clk_i or negedge arstn_i)
        if (!arstn_i) begin hd1 <= '0; hd2 <= '0; end
        else begin hd1 <= payload_bytes_o; hd2 <= hd1; end
    always_comb begin
        header_i = '0;
        for (int n = 0; n < HB; n++) header_i[n*8 +: 8] = hbyte(hd2, n);
    end

    // Source models: byte index per source, restarted by each grant
    logic [PW:0] src_idx [NS];
    always @(posedge clk_i or negedge arstn_i)
        if (!arstn_i) begin
            for (int k = 0; k < NS; k++) src_idx[k] <= '0;
        end else begin
            for (int k = 0; k < NS; k++)
                if (req_ack_o[k]) src_idx[k] <= '0;
                else if (s_valid_i[k] && s_ready_o[k]) src_idx[k] <= src_idx[k] + 1'b1;
        end
    always_comb
        for (int k = 0; k < NS; k++) s_data_i[k*8 +: 8] = pbyte(k, int'(src_idx[k]));

    // Random backpressure / source stalls
    logic stall_en = 1'b0;
    always @(posedge clk_i) begin
        #1;
        if (stall_en) begin
            m_ready_i = ($urandom_range(0, 3) != 0);
            s_valid_i = NS'($urandom);
        end else begin
            m_ready_i = 1'b1;
            s_valid_i = '1;
        end
    end

    // Scoreboard
    logic [8:0] exp_q[$];
    int         gq[$];
    int         lq[$];

    task automatic push_frame(input int src, input int len);
        for (int n = 0; n < HB; n++) exp_q.push_back({1'b0, hbyte(PW'(len), n)});
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) && (HB + len >= MIN), pbyte(src, i)});
        for (int t = HB + len; t < MIN; t++) exp_q.push_back({t == MIN - 1, 8'h00});
        gq.push_back(src);
        lq.push_back(len);
    endtask

    // Monitor
    int         cur_g = 0, cur_len = 0, gap_left = 0, frame_bytes = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    always @(negedge clk_i) begin
        if (arstn_i) begin
            logic [NS-1:0] mask;
            logic [8:0]    e;
            int            g, l;
            if (req_ack_o != '0) begin
                n_test++;
                frame_bytes = 0;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected got=%b exp=none", req_ack_o);
                end else begin
                    g = gq.pop_front();
                    l = lq.pop_front();
                    if (req_ack_o != NS'(1 << g) || grant_o != 2'(g) || payload_bytes_o != PW'(l)) begin
                        n_fail++;
                        $display("FAIL grant got ack=%b grant=%0d len=%0d exp ack=%b grant=%0d len=%0d",
                                 req_ack_o, grant_o, payload_bytes_o, NS'(1 << g), g, l);
                    end
                    cur_g = g;
                    cur_len = l;
                end
            end
            if (s_ready_o != '0) begin
                mask = (cur_len != 0) ? NS'(1 << cur_g) : '0;
                n_test++;
                if ((s_ready_o & ~mask) != '0) begin
                    n_fail++;
                    $display("FAIL s_ready got=%b allowed=%b", s_ready_o, mask);
                end
            end
            if (prev_stall && m_valid_o) begin
                n_test++;
                if ({m_last_o, m_data_o} != prev_word) begin
                    n_fail++;
                    $display("FAIL stall_hold got=%h exp=%h", {m_last_o, m_data_o}, prev_word);
                end
            end
            if (gap_left > 0) begin
                n_test++;
                if (m_valid_o || !busy_o) begin
                    n_fail++;
                    $display("FAIL ifg got valid=%b busy=%b exp valid=0 busy=1", m_valid_o, busy_o);
                end
                gap_left--;
            end else if (m_valid_o && m_ready_i) begin
                n_test++;
                frame_bytes++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_extra got=%h exp=none", {m_last_o, m_data_o});
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last_o, m_data_o} != e) begin
                        n_fail++;
                        $display("FAIL byte %0d got last=%b data=%h exp last=%b data=%h",
                                 frame_bytes, m_last_o, m_data_o, e[8], e[7:0]);
                    end
                end
                if (m_last_o) gap_left = IFG;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = {m_last_o, m_data_o};
        end
    end

    task automatic set_len(input int k, input int l);
        req_len_i[k*PW +: PW] = PW'(l);
    endtask

    task automatic run_req(input logic [NS-1:0] m, input int n);
        int cnt = 0, cyc = 0;
        req_valid_i = m;
        while (cnt < n && cyc < 5000) begin
            @(negedge clk_i);
            if (req_ack_o != '0) cnt++;
            cyc++;
        end
        req_valid_i = '0;
        if (cnt < n) begin
            n_test++; n_fail++;
            $display("FAIL ack_timeout got=%0d exp=%0d", cnt, n);
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || busy_o) && cyc < 10000) begin
            @(negedge clk_i);
            cyc++;
        end
        if (cyc >= 10000) begin
            n_test++; n_fail++;
            $display("FAIL drain_timeout got=%0d exp=0 bytes left", exp_q.size());
        end
    endtask

    task automatic check_zero(input string nm);
        n_test++;
        if ({req_ack_o, s_ready_o, payload_bytes_o, m_data_o, m_valid_o, m_last_o, busy_o, grant_o} != '0) begin
            n_fail++;
            $display("FAIL %s got ack=%b rdy=%b pb=%0d d=%h v=%b l=%b busy=%b g=%0d exp all 0", nm,
                     req_ack_o, s_ready_o, payload_bytes_o, m_data_o, m_valid_o, m_last_o, busy_o, grant_o);
        end
    endtask

    initial begin
        int cyc;
        #3;
        check_zero("reset_state");
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(negedge clk_i);

        // Single source, long payload, then short payloads needing padding
        set_len(0, 100); push_frame(0, 100); run_req(4'b0001, 1); drain();
        set_len(0, 5);   push_frame(0, 5);   run_req(4'b0001, 1); drain();
        set_len(0, 0);   push_frame(0, 0);   run_req(4'b0001, 1); drain();

        // Reset in the middle of the payload
        set_len(1, 30); push_frame(1, 30); run_req(4'b0010, 1);
        cyc = 0;
        while (frame_bytes < 50 && cyc < 1000) begin @(negedge clk_i); cyc++; end
        if (cyc >= 1000) begin
            n_test++; n_fail++;
            $display("FAIL midframe_timeout got=%0d exp=50", frame_bytes);
        end
        #2 arstn_i = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete(); gq.delete(); lq.delete();
        cur_len = 0; gap_left = 0; prev_stall = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        arstn_i = 1'b1;

        // All sources requesting: rotation restarts at source 0
        set_len(0, 10); set_len(1, 3); set_len(2, 25); set_len(3, 0);
        push_frame(0, 10); push_frame(1, 3); push_frame(2, 25); push_frame(3, 0); push_frame(0, 10);
        run_req(4'b1111, 5); drain();

        // Random stalls on both sides
        stall_en = 1'b1;
        set_len(1, 20); push_frame(1, 20); run_req(4'b0010, 1); drain();
        set_len(3, 7);  push_frame(3, 7);  run_req(4'b1000, 1); drain();
        set_len(2, 30); push_frame(2, 30); run_req(4'b0100, 1); drain();
        stall_en = 1'b0;
        repeat (3) @(negedge clk_i);

        n_test++;
        if (exp_q.size() != 0 || gq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got bytes=%0d grants=%0d exp 0", exp_q.size(), gq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Arbitrates NUM_SRC UDP payload sources onto one byte-wide Ethernet TX stream.
- Per frame:
  - grants one requester (round-robin) and drives its payload length to the Ethernet/IPv4/UDP header generator;
  - waits for the header to settle, then serialises the 42 header bytes;
  - streams the granted source's payload;
  - zero-pads to the 60-byte minimum frame and enforces an inter-frame gap.
- Sits between the application sources and the MAC (preamble/FCS inserter).

Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- PAYLOAD_WIDTH, 11, width of payload byte counts
- HDR_BYTES, 42, header length in bytes (14 Eth + 20 IPv4 + 8 UDP)
- HDR_LATENCY, 2, cycles from payload_bytes_o change to header_i valid
- MIN_FRAME_BYTES, 60, minimum frame length excluding FCS
- IFG_CYCLES, 12, idle cycles after each frame's last byte

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  async reset, active low
- req_valid_i  in  NUM_SRC  source k has a frame pending
- req_len_i  in  NUM_SRC*PAYLOAD_WIDTH  payload bytes of source k, slice [k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
- req_ack_o  out  NUM_SRC  one-cycle grant pulse to source k
- s_data_i  in  NUM_SRC*8  payload byte of source k
- s_valid_i  in  NUM_SRC  payload byte valid
- s_ready_o  out  NUM_SRC  payload byte accepted
- payload_bytes_o  out  PAYLOAD_WIDTH  to header generator
- header_i  in  HDR_BYTES*8  header; wire byte n = header_i[8n+7:8n]
- m_data_o  out  8  TX byte
- m_valid_o  out  1  TX byte valid
- m_last_o  out  1  last byte of frame
- m_ready_i  in  1  downstream accepts byte
- busy_o  out  1  frame in progress (any state other than IDLE)
- grant_o  out  $clog2(NUM_SRC)  index of current/last grant

Behaviour:
- Interface: one clock clk_i; reset arstn_i is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - round-robin pointer 0 (source 0 has highest priority first);
  - state IDLE.
  - Reset mid-frame aborts immediately: m_valid_o drops with no m_last_o; the frame is lost.
- IDLE, any req_valid_i set:
  - pick the first requester at or after the pointer, cyclic;
  - pulse its req_ack_o for 1 cycle;
  - latch len = its req_len_i and register payload_bytes_o = len;
  - grant_o = g; pointer = g+1 mod NUM_SRC;
  - next state HDR_WAIT.
- HDR_WAIT: count HDR_LATENCY cycles, then go to HDR. payload_bytes_o holds until the next grant.
- HDR:
  - m_valid_o=1, m_data_o = header byte n, n = 0..HDR_BYTES-1;
  - n advances only on m_valid_o & m_ready_i;
  - after byte HDR_BYTES-1 is accepted: go to PAYLOAD if len>0, else PAD.
- PAYLOAD:
  - m_valid_o = s_valid_i[g]; m_data_o = s_data_i[g];
  - s_ready_o[g] = m_ready_i; all other s_ready_o = 0;
  - count accepted bytes;
  - at byte len: go to PAD if HDR_BYTES+len < MIN_FRAME_BYTES, else GAP with m_last_o asserted on that byte.
- PAD:
  - m_valid_o=1, m_data_o=0x00 until total accepted bytes = MIN_FRAME_BYTES;
  - m_last_o on the final pad byte; then GAP.
- GAP: m_valid_o=0 for IFG_CYCLES cycles, then IDLE.
  - Requests are not evaluated during GAP.
  - Back-to-back throughput: one frame per (arbitration + HDR_LATENCY + bytes + IFG) cycles.
- Output stream rules:
  - m_data_o and m_last_o are held stable while m_valid_o & !m_ready_i;
  - m_valid_o is never deasserted while !m_ready_i, except in PAYLOAD where it follows the source.
- req_valid_i changes after the grant are ignored until the next IDLE.
- A source that deasserts s_valid_i stalls the frame indefinitely; the block has no timeout.
- Arithmetic: byte counters are PAYLOAD_WIDTH+1 bits; len = 2^PAYLOAD_WIDTH-1 must not wrap.

Test Plan:
- Single source 0, len=100, m_ready_i=1:
  - req_ack_o[0] one pulse; payload_bytes_o=100;
  - 42 header bytes matching header_i byte order, then 100 payload bytes;
  - m_last_o on byte 142; then 12 idle cycles.
- len=5: 42 header + 5 payload + 13 bytes 0x00; m_last_o on byte 60.
- len=0: header then 18 zero bytes; s_ready_o never asserted.
- All 4 sources requesting continuously:
  - grants rotate 0,1,2,3,0;
  - each frame's payload comes only from the granted source; other s_ready_o stay 0.
- Random m_ready_i and s_valid_i stalls: output byte sequence is identical to the no-stall run; data is stable during stalls.
- arstn_i low in the middle of the payload:
  - all outputs go to 0 asynchronously; no m_last_o;
  - after release the next grant starts at source 0 with a fresh header.
